// File: rtl/tc_program_fetch_arbiter.sv
// tc_program_fetch_arbiter
// Shares one 4-word program-memory read port between the CPU fetch unit (F)
// and a debug/loader reader (D). One transaction in flight at a time:
// IDLE (arbitrate) -> ISSUE (mem_en, gnt) -> WAIT (latency countdown,
// capture) -> RESP (rsp_valid). All outputs are registered.
// Optional build macro TC_PFA_LINE_CACHE_EN keeps the last F line so that a
// repeated F fetch is served without touching memory.
module tc_program_fetch_arbiter #(
  parameter int BIT_WIDTH    = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_gnt,
  output logic                  f_rsp_valid,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  output logic                  d_gnt,
  output logic                  d_rsp_valid,
  output logic [BIT_WIDTH-1:0]  rsp_data0,
  output logic [BIT_WIDTH-1:0]  rsp_data1,
  output logic [BIT_WIDTH-1:0]  rsp_data2,
  output logic [BIT_WIDTH-1:0]  rsp_data3,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [BIT_WIDTH-1:0]  mem_data0,
  input  logic [BIT_WIDTH-1:0]  mem_data1,
  input  logic [BIT_WIDTH-1:0]  mem_data2,
  input  logic [BIT_WIDTH-1:0]  mem_data3
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  logic       owner;        // 0 = fetch unit, 1 = debug reader
  logic [3:0] starve_cnt;
  logic [2:0] wait_cnt;
  logic       starve_full;
  logic       d_wins;

`ifdef TC_PFA_LINE_CACHE_EN
  logic                  cache_valid;
  logic [ADDR_WIDTH-1:0] cache_addr;
  logic [BIT_WIDTH-1:0]  cache_w0;
  logic [BIT_WIDTH-1:0]  cache_w1;
  logic [BIT_WIDTH-1:0]  cache_w2;
  logic [BIT_WIDTH-1:0]  cache_w3;
  logic                  cache_hit;

  assign cache_hit = cache_valid && (cache_addr == f_addr);
`endif

  // D only wins against a competing F once it has been passed over STARVE_LIMIT times
  assign starve_full = (starve_cnt == 4'(STARVE_LIMIT));
  assign d_wins      = d_req && (!f_req || starve_full);

  // Transaction sequencer: arbitration, issue, latency wait, response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      starve_cnt  <= '0;
      wait_cnt    <= '0;
      f_gnt       <= 1'b0;
      d_gnt       <= 1'b0;
      f_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      mem_en      <= 1'b0;
      mem_addr    <= '0;
      rsp_data0   <= '0;
      rsp_data1   <= '0;
      rsp_data2   <= '0;
      rsp_data3   <= '0;
`ifdef TC_PFA_LINE_CACHE_EN
      cache_valid <= 1'b0;
      cache_addr  <= '0;
      cache_w0    <= '0;
      cache_w1    <= '0;
      cache_w2    <= '0;
      cache_w3    <= '0;
`endif
    end else begin
      f_gnt       <= 1'b0;
      d_gnt       <= 1'b0;
      f_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      mem_en      <= 1'b0;
      case (state)
        IDLE: begin
          if (!d_req) starve_cnt <= '0;
          if (d_wins) begin
            owner      <= 1'b1;
            starve_cnt <= '0;
            d_gnt      <= 1'b1;
            mem_en     <= 1'b1;
            mem_addr   <= d_addr;
            state      <= ISSUE;
`ifdef TC_PFA_LINE_CACHE_EN
            cache_valid <= 1'b0;
`endif
          end else if (f_req) begin
            owner <= 1'b0;
            if (d_req && !starve_full) starve_cnt <= starve_cnt + 4'd1;
`ifdef TC_PFA_LINE_CACHE_EN
            if (cache_hit) begin
              // Hit: grant and respond together straight from the line buffer
              f_gnt       <= 1'b1;
              f_rsp_valid <= 1'b1;
              rsp_data0   <= cache_w0;
              rsp_data1   <= cache_w1;
              rsp_data2   <= cache_w2;
              rsp_data3   <= cache_w3;
              state       <= RESP;
            end else begin
              f_gnt    <= 1'b1;
              mem_en   <= 1'b1;
              mem_addr <= f_addr;
              state    <= ISSUE;
            end
`else
            f_gnt    <= 1'b1;
            mem_en   <= 1'b1;
            mem_addr <= f_addr;
            state    <= ISSUE;
`endif
          end
        end
        ISSUE: begin
          // Data arrives in the last of MEM_LATENCY WAIT cycles
          wait_cnt <= 3'(MEM_LATENCY - 1);
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 3'd0) begin
            rsp_data0   <= mem_data0;
            rsp_data1   <= mem_data1;
            rsp_data2   <= mem_data2;
            rsp_data3   <= mem_data3;
            f_rsp_valid <= !owner;
            d_rsp_valid <= owner;
            state       <= RESP;
`ifdef TC_PFA_LINE_CACHE_EN
            if (!owner) begin
              cache_valid <= 1'b1;
              cache_addr  <= mem_addr;
              cache_w0    <= mem_data0;
              cache_w1    <= mem_data1;
              cache_w2    <= mem_data2;
              cache_w3    <= mem_data3;
            end
`endif
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tc_program_fetch_arbiter.sv
// Bench for tc_program_fetch_arbiter: a latency-1 instance driven from a
// vector table and corner-case sequences with a response scoreboard, plus a
// latency-3 instance for exact data-sampling timing.
module tb_tc_program_fetch_arbiter;

  localparam int L1 = 1;
  localparam int L3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   mem_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // latency-1 instance signals
  logic        f_req = 1'b0, d_req = 1'b0;
  logic [15:0] f_addr = '0, d_addr = '0;
  logic        f_gnt, f_rsp_valid, d_gnt, d_rsp_valid, mem_en;
  logic [15:0] mem_addr, rsp_data0, rsp_data1, rsp_data2, rsp_data3;
  logic [15:0] mem_data0, mem_data1, mem_data2, mem_data3;

  // latency-3 instance signals
  logic        f_req3 = 1'b0, d_req3 = 1'b0;
  logic [15:0] f_addr3 = '0, d_addr3 = '0;
  logic        f_gnt3, f_rsp_valid3, d_gnt3, d_rsp_valid3, mem_en3;
  logic [15:0] mem_addr3, rsp3_0, rsp3_1, rsp3_2, rsp3_3;
  logic [15:0] mem3_0, mem3_1, mem3_2, mem3_3;

  tc_program_fetch_arbiter #(.BIT_WIDTH(16), .ADDR_WIDTH(16), .MEM_LATENCY(L1), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rsp_valid(f_rsp_valid),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rsp_valid(d_rsp_valid),
    .rsp_data0(rsp_data0), .rsp_data1(rsp_data1), .rsp_data2(rsp_data2), .rsp_data3(rsp_data3),
    .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_data0(mem_data0), .mem_data1(mem_data1), .mem_data2(mem_data2), .mem_data3(mem_data3)
  );

  tc_program_fetch_arbiter #(.BIT_WIDTH(16), .ADDR_WIDTH(16), .MEM_LATENCY(L3), .STARVE_LIMIT(4)) dut3 (
    .clk(clk), .rst(rst),
    .f_req(f_req3), .f_addr(f_addr3), .f_gnt(f_gnt3), .f_rsp_valid(f_rsp_valid3),
    .d_req(d_req3), .d_addr(d_addr3), .d_gnt(d_gnt3), .d_rsp_valid(d_rsp_valid3),
    .rsp_data0(rsp3_0), .rsp_data1(rsp3_1), .rsp_data2(rsp3_2), .rsp_data3(rsp3_3),
    .mem_en(mem_en3), .mem_addr(mem_addr3),
    .mem_data0(mem3_0), .mem_data1(mem3_1), .mem_data2(mem3_2), .mem_data3(mem3_3)
  );

  // Memory contents: address 4 holds 11,22,33,44; elsewhere a scrambled address
  function automatic logic [15:0] word(input logic [15:0] a, input int i);
    logic [15:0] ai;
    ai = a + 16'(i);
    if (a == 16'h0004) return 16'(11 * (i + 1));
    return ai ^ 16'h5A3C;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Memory models: words valid only in the cycle exactly L cycles after mem_en
  logic [16:0] pipe1 [8];
  logic [16:0] pipe3 [8];
  always @(posedge clk) begin
    pipe1[0] <= {mem_en, mem_addr};
    pipe3[0] <= {mem_en3, mem_addr3};
    for (int k = 1; k < 8; k++) begin
      pipe1[k] <= pipe1[k-1];
      pipe3[k] <= pipe3[k-1];
    end
  end

  always_comb begin
    mem_data0 = 16'hDEAD; mem_data1 = 16'hDEAE; mem_data2 = 16'hDEAF; mem_data3 = 16'hDEB0;
    if (pipe1[L1-1][16] === 1'b1) begin
      mem_data0 = word(pipe1[L1-1][15:0], 0);
      mem_data1 = word(pipe1[L1-1][15:0], 1);
      mem_data2 = word(pipe1[L1-1][15:0], 2);
      mem_data3 = word(pipe1[L1-1][15:0], 3);
    end
  end

  always_comb begin
    mem3_0 = 16'hBEEF; mem3_1 = 16'hBEF0; mem3_2 = 16'hBEF1; mem3_3 = 16'hBEF2;
    if (pipe3[L3-1][16] === 1'b1) begin
      mem3_0 = word(pipe3[L3-1][15:0], 0);
      mem3_1 = word(pipe3[L3-1][15:0], 1);
      mem3_2 = word(pipe3[L3-1][15:0], 2);
      mem3_3 = word(pipe3[L3-1][15:0], 3);
    end
  end

  // Scoreboard of expected transactions on the latency-1 instance
  typedef struct {
    logic        is_d;
    logic [15:0] addr;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst) begin
      if (f_gnt || d_gnt) begin
        chk("gnt_exclusive", 128'(f_gnt & d_gnt), 128'(0));
        chk("gnt_expected", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) chk("gnt_owner", 128'(d_gnt), 128'(exp_q[0].is_d));
      end
      if (mem_en) begin
        mem_cnt = mem_cnt + 1;
        if (exp_q.size() != 0) chk("mem_addr", 128'(mem_addr), 128'(exp_q[0].addr));
      end
      if (f_rsp_valid || d_rsp_valid) begin
        chk("rsp_exclusive", 128'(f_rsp_valid & d_rsp_valid), 128'(0));
        chk("rsp_expected", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("rsp_owner", 128'(d_rsp_valid), 128'(mon_e.is_d));
          chk("rsp_data", {rsp_data0, rsp_data1, rsp_data2, rsp_data3},
              {word(mon_e.addr, 0), word(mon_e.addr, 1), word(mon_e.addr, 2), word(mon_e.addr, 3)});
        end
      end
    end
  end

  // One transaction on the latency-1 instance; latencies measured from the drive cycle
  task automatic txn(input logic is_d, input logic [15:0] a, output int gl, output int rl);
    int   t0;
    exp_t e;
    @(negedge clk);
    e.is_d = is_d;
    e.addr = a;
    exp_q.push_back(e);
    if (is_d) begin d_req = 1'b1; d_addr = a; end
    else begin f_req = 1'b1; f_addr = a; end
    t0 = cyc;
    gl = -1;
    rl = -1;
    for (int i = 0; i < 20 && gl < 0; i++) begin
      @(negedge clk);
      if (is_d ? d_gnt : f_gnt) gl = cyc - t0;
    end
    f_req = 1'b0;
    d_req = 1'b0;
    for (int i = 0; i < 20 && rl < 0 && gl >= 0; i++) begin
      if (is_d ? d_rsp_valid : f_rsp_valid) rl = cyc - t0;
      else @(negedge clk);
    end
  endtask

  typedef struct {
    logic        is_d;
    logic [15:0] addr;
    int          gl;
    int          rl;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   gl, rl, m0, n, t0, me;
    logic glog [10];
    logic exp_ord [10];

    tbl[0] = '{1'b0, 16'h0004, 1, 3};
    tbl[1] = '{1'b1, 16'hFFFE, 1, 3};
    tbl[2] = '{1'b0, 16'h1234, 1, 3};
    tbl[3] = '{1'b1, 16'h0007, 1, 3};
    tbl[4] = '{1'b0, 16'h00FF, 1, 3};
    tbl[5] = '{1'b0, 16'h8000, 1, 3};
    exp_ord = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {f_gnt, d_gnt, f_rsp_valid, d_rsp_valid, mem_en, mem_addr,
                          rsp_data0, rsp_data1, rsp_data2, rsp_data3}, 128'(0));
    chk("reset_outputs3", {f_gnt3, d_gnt3, f_rsp_valid3, d_rsp_valid3, mem_en3, mem_addr3,
                           rsp3_0, rsp3_1, rsp3_2, rsp3_3}, 128'(0));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Table of single transactions
    for (int i = 0; i < 6; i++) begin
      m0 = mem_cnt;
      txn(tbl[i].is_d, tbl[i].addr, gl, rl);
      chk($sformatf("vec%0d_gnt_lat", i), 128'(gl), 128'(tbl[i].gl));
      chk($sformatf("vec%0d_rsp_lat", i), 128'(rl), 128'(tbl[i].rl));
      chk($sformatf("vec%0d_mem_en_count", i), 128'(mem_cnt - m0), 128'(1));
      if (i == 0)
        chk("f4_data", {rsp_data0, rsp_data1, rsp_data2, rsp_data3},
            {16'd11, 16'd22, 16'd33, 16'd44});
    end

    // Both requesters held: D forced in after four consecutive F wins
    for (int i = 0; i < 10; i++) exp_q.push_back('{exp_ord[i], exp_ord[i] ? 16'h0300 : 16'h0200});
    for (int i = 0; i < 10; i++) glog[i] = 1'bx;
    @(negedge clk);
    f_req = 1'b1; f_addr = 16'h0200;
    d_req = 1'b1; d_addr = 16'h0300;
    n = 0;
    for (int i = 0; i < 200 && n < 10; i++) begin
      @(negedge clk);
      if (f_gnt || d_gnt) begin
        glog[n] = d_gnt;
        n = n + 1;
        if (n == 10) begin f_req = 1'b0; d_req = 1'b0; end
      end
    end
    f_req = 1'b0;
    d_req = 1'b0;
    chk("starve_grant_count", 128'(n), 128'(10));
    for (int i = 0; i < 10; i++) chk($sformatf("starve_order%0d", i), 128'(glog[i]), 128'(exp_ord[i]));
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    chk("starve_drain", 128'(exp_q.size()), 128'(0));

    // Reset in the middle of WAIT aborts the transaction
    @(negedge clk);
    exp_q.push_back('{1'b0, 16'h0010});
    f_req = 1'b1; f_addr = 16'h0010;
    gl = -1;
    for (int i = 0; i < 20 && gl < 0; i++) begin
      @(negedge clk);
      if (f_gnt) gl = 1;
    end
    f_req = 1'b0;
    chk("abort_gnt_seen", 128'(gl), 128'(1));
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_outputs", {f_gnt, d_gnt, f_rsp_valid, d_rsp_valid, mem_en, mem_addr,
                          rsp_data0, rsp_data1, rsp_data2, rsp_data3}, 128'(0));
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_rsp", 128'(f_rsp_valid), 128'(0));
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_idle", 128'({f_rsp_valid, f_gnt, mem_en}), 128'(0));
    end
    m0 = mem_cnt;
    txn(1'b0, 16'h0010, gl, rl);
    chk("post_abort_gnt_lat", 128'(gl), 128'(1));
    chk("post_abort_rsp_lat", 128'(rl), 128'(3));
    chk("post_abort_mem_en", 128'(mem_cnt - m0), 128'(1));

    // Latency-3 instance: data sampled exactly three cycles after mem_en
    @(negedge clk);
    f_req3 = 1'b1; f_addr3 = 16'h0100;
    t0 = cyc; gl = -1; me = -1; rl = -1;
    for (int i = 0; i < 30 && rl < 0; i++) begin
      @(negedge clk);
      if (f_gnt3 && gl < 0) begin gl = cyc - t0; f_req3 = 1'b0; end
      if (mem_en3 && me < 0) me = cyc - t0;
      if (f_rsp_valid3) rl = cyc - t0;
    end
    f_req3 = 1'b0;
    chk("lat3_gnt_lat", 128'(gl), 128'(1));
    chk("lat3_mem_en_lat", 128'(me), 128'(1));
    chk("lat3_rsp_lat", 128'(rl), 128'(5));
    chk("lat3_data", {rsp3_0, rsp3_1, rsp3_2, rsp3_3},
        {word(16'h0100, 0), word(16'h0100, 1), word(16'h0100, 2), word(16'h0100, 3)});
    chk("lat3_no_d", 128'({d_gnt3, d_rsp_valid3}), 128'(0));

`ifdef TC_PFA_LINE_CACHE_EN
    // Line cache: repeat F hits, D transaction invalidates
    m0 = mem_cnt;
    txn(1'b0, 16'h0040, gl, rl);
    chk("cache_fill_rsp_lat", 128'(rl), 128'(3));
    chk("cache_fill_mem_en", 128'(mem_cnt - m0), 128'(1));
    m0 = mem_cnt;
    txn(1'b0, 16'h0040, gl, rl);
    chk("cache_hit_gnt_lat", 128'(gl), 128'(1));
    chk("cache_hit_rsp_lat", 128'(rl), 128'(1));
    chk("cache_hit_mem_en", 128'(mem_cnt - m0), 128'(0));
    txn(1'b1, 16'h0050, gl, rl);
    m0 = mem_cnt;
    txn(1'b0, 16'h0040, gl, rl);
    chk("cache_inval_rsp_lat", 128'(rl), 128'(3));
    chk("cache_inval_mem_en", 128'(mem_cnt - m0), 128'(1));
`endif

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
